mem_port_arbiter: RTL and testbench

- Shares the single-port 4096x16 program/data memory between three requesters: instruction fetch (`if_`), CPU data/stack access (`dm_`), and a DMA/debug loader (`dma_`).
- Sits between the CPU core and the memory; it is the only driver of the memory's `address`, `data_in` and `write_enable`.
- The memory writes on posedge when `write_enable` is high and reads on negedge when it is low. The arbiter therefore issues one access per two-cycle window, using fixed priority plus DMA anti-starvation aging.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/grant handshakes for fetch, data and DMA requesters plus the
// memory-side address/data/enable bundle driven by mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_data_out;

  // Arbiter side: sees requests and memory read data, drives everything else.
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_data_out,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, dma_gnt, dma_rvalid,
    output rdata, busy, mem_address, mem_data_in, mem_write_enable
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_data_out,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, dma_gnt, dma_rvalid,
    input  rdata, busy, mem_address, mem_data_in, mem_write_enable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data memory between fetch, data and DMA.
// One access per two-cycle window; fixed priority dm > if > dma with DMA aging.
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_DM, SRC_DMA} src_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t            state_q, state_d;
  src_t              owner_q, owner_d;
  src_t              winner;
  logic [7:0]        starve_q, starve_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;

  // A starved DMA overrides the normal priority order.
  always_comb begin
    winner = SRC_NONE;
    if (bus.dma_req && starve_q == LIMIT) winner = SRC_DMA;
    else if (bus.dm_req)                  winner = SRC_DM;
    else if (bus.if_req)                  winner = SRC_IF;
    else if (bus.dma_req)                 winner = SRC_DMA;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    gnt_d    = 3'b000;
    rvalid_d = 3'b000;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    busy_d   = 1'b0;

    if (!bus.dma_req) starve_d = 8'd0;

    case (state_q)
      IDLE: begin
        if (winner != SRC_NONE) begin
          state_d = ACCESS;
          owner_d = winner;
          busy_d  = 1'b1;
          if (bus.dma_req) begin
            if (winner == SRC_DMA)      starve_d = 8'd0;
            else if (starve_q == LIMIT) starve_d = starve_q;
            else                        starve_d = starve_q + 8'd1;
          end
          case (winner)
            SRC_IF: begin
              addr_d   = bus.if_addr;
              wdata_d  = '0;
              gnt_d[0] = 1'b1;
            end
            SRC_DM: begin
              addr_d   = bus.dm_addr;
              we_d     = bus.dm_we;
              wdata_d  = bus.dm_we ? bus.dm_wdata : '0;
              gnt_d[1] = 1'b1;
            end
            SRC_DMA: begin
              addr_d   = bus.dma_addr;
              we_d     = bus.dma_we;
              wdata_d  = bus.dma_we ? bus.dma_wdata : '0;
              gnt_d[2] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ACCESS: begin
        state_d = IDLE;
        owner_d = SRC_NONE;
        // The write commits at this edge inside the memory; only reads return data.
        if (!we_q) begin
          rdata_d = bus.mem_data_out;
          case (owner_q)
            SRC_IF:  rvalid_d[0] = 1'b1;
            SRC_DM:  rvalid_d[1] = 1'b1;
            SRC_DMA: rvalid_d[2] = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= SRC_NONE;
      starve_q <= 8'd0;
      gnt_q    <= 3'b000;
      rvalid_q <= 3'b000;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.if_gnt           = gnt_q[0];
  assign bus.dm_gnt           = gnt_q[1];
  assign bus.dma_gnt          = gnt_q[2];
  assign bus.if_rvalid        = rvalid_q[0];
  assign bus.dm_rvalid        = rvalid_q[1];
  assign bus.dma_rvalid       = rvalid_q[2];
  assign bus.rdata            = rdata_q;
  assign bus.busy             = busy_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data_in      = wdata_q;
  assign bus.mem_write_enable = we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural memory, transaction-level
// arbitration/aging model, directed scenarios followed by random traffic.
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 8;
  localparam int DEPTH        = 1 << ADDR_W;
  localparam int IF           = 1;
  localparam int DM           = 2;
  localparam int DMA          = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int compare_count = 0;
  int fail_count    = 0;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ref_starve = 0;
  logic [DATA_W-1:0] ref_rdata  = '0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 5) return 16'h7CFF;
    return 16'(i * 40503 + 15450);
  endfunction

  // Single-port memory: write on posedge when enabled, read on negedge otherwise.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    bus.mem_data_out = '0;
    forever begin
      @(clk);
      if (clk) begin
        if (bus.mem_write_enable) mem[bus.mem_address] = bus.mem_data_in;
      end else if (!bus.mem_write_enable) begin
        bus.mem_data_out = mem[bus.mem_address];
      end
    end
  end

  function automatic logic [2:0] gnt_vec();
    return {bus.dma_gnt, bus.dm_gnt, bus.if_gnt};
  endfunction

  function automatic logic [2:0] rvalid_vec();
    return {bus.dma_rvalid, bus.dm_rvalid, bus.if_rvalid};
  endfunction

  function automatic logic req_of(input int who);
    case (who)
      IF:      return bus.if_req;
      DM:      return bus.dm_req;
      default: return bus.dma_req;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 3) return 12'($urandom);
    return 12'($urandom_range(0, 15));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int who, input logic req, input logic we,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    case (who)
      IF: begin
        bus.if_req  = req;
        bus.if_addr = addr;
      end
      DM: begin
        bus.dm_req   = req;
        bus.dm_we    = we;
        bus.dm_addr  = addr;
        bus.dm_wdata = wdata;
      end
      default: begin
        bus.dma_req   = req;
        bus.dma_we    = we;
        bus.dma_addr  = addr;
        bus.dma_wdata = wdata;
      end
    endcase
  endtask

  task automatic new_request(input int who);
    logic we;
    we = (who == IF) ? 1'b0 : 1'($urandom_range(0, 1));
    applyStimulus(who, 1'b1, we, rand_addr(), 16'($urandom));
  endtask

  // One arbitration window starting from IDLE: predicts the winner from the
  // priority/aging rules and checks the grant cycle and the completion cycle.
  task automatic arbitrate(output int who, output logic [2:0] seen);
    int                exp_who;
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [DATA_W-1:0] d;
    logic [2:0]        exp_gnt;

    if (bus.dma_req && ref_starve >= STARVE_LIMIT) exp_who = DMA;
    else if (bus.dm_req)                           exp_who = DM;
    else if (bus.if_req)                           exp_who = IF;
    else if (bus.dma_req)                          exp_who = DMA;
    else                                           exp_who = 0;

    a = '0; w = 1'b0; d = '0;
    case (exp_who)
      IF:  a = bus.if_addr;
      DM:  begin a = bus.dm_addr;  w = bus.dm_we;  d = w ? bus.dm_wdata  : '0; end
      DMA: begin a = bus.dma_addr; w = bus.dma_we; d = w ? bus.dma_wdata : '0; end
      default: ;
    endcase

    if (!bus.dma_req || exp_who == DMA) ref_starve = 0;
    else if (ref_starve < STARVE_LIMIT) ref_starve++;

    exp_gnt = (exp_who == 0) ? 3'b000 : 3'(3'b001 << (exp_who - 1));

    @(posedge clk); #1;
    seen = gnt_vec();
    who  = exp_who;
    checkOutput("gnt", 32'(seen), 32'(exp_gnt));
    checkOutput("rvalid_pulse", 32'(rvalid_vec()), 32'd0);
    checkOutput("busy", 32'(bus.busy), 32'(exp_who != 0));
    if (exp_who == 0) begin
      checkOutput("we_idle", 32'(bus.mem_write_enable), 32'd0);
      return;
    end
    checkOutput("mem_address", 32'(bus.mem_address), 32'(a));
    checkOutput("mem_we", 32'(bus.mem_write_enable), 32'(w));
    checkOutput("mem_data_in", 32'(bus.mem_data_in), 32'(d));

    @(posedge clk); #1;
    if (!bus.dma_req) ref_starve = 0;
    if (w) ref_mem[a] = d;
    else   ref_rdata  = ref_mem[a];
    checkOutput("rvalid", 32'(rvalid_vec()), w ? 32'd0 : 32'(exp_gnt));
    checkOutput("rdata", 32'(bus.rdata), 32'(ref_rdata));
    checkOutput("gnt_clear", 32'(gnt_vec()), 32'd0);
    checkOutput("we_clear", 32'(bus.mem_write_enable), 32'd0);
    checkOutput("busy_clear", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int                who;
    int                dm_grants;
    logic [2:0]        seen;
    logic [DATA_W-1:0] saved;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    for (int k = IF; k <= DMA; k++) applyStimulus(k, 1'b0, 1'b0, '0, '0);

    #1 reset = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_gnt", 32'(gnt_vec()), 32'd0);
    checkOutput("rst_rvalid", 32'(rvalid_vec()), 32'd0);
    checkOutput("rst_we", 32'(bus.mem_write_enable), 32'd0);
    checkOutput("rst_addr", 32'(bus.mem_address), 32'd0);
    checkOutput("rst_data_in", 32'(bus.mem_data_in), 32'd0);
    checkOutput("rst_rdata", 32'(bus.rdata), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single fetch read");
    applyStimulus(IF, 1'b1, 1'b0, 12'd5, '0);
    arbitrate(who, seen);
    checkOutput("t1_rdata", 32'(bus.rdata), 32'h7CFF);
    applyStimulus(IF, 1'b0, 1'b0, '0, '0);
    arbitrate(who, seen);

    $display("[TB] write then read");
    applyStimulus(DM, 1'b1, 1'b1, 12'h010, 16'hA5A5);
    arbitrate(who, seen);
    applyStimulus(DM, 1'b1, 1'b0, 12'h010, '0);
    arbitrate(who, seen);
    checkOutput("t2_rdata", 32'(bus.rdata), 32'hA5A5);
    applyStimulus(DM, 1'b0, 1'b0, '0, '0);

    $display("[TB] fixed priority");
    applyStimulus(IF, 1'b1, 1'b0, 12'h020, '0);
    applyStimulus(DM, 1'b1, 1'b0, 12'h021, '0);
    applyStimulus(DMA, 1'b1, 1'b0, 12'h022, '0);
    arbitrate(who, seen);
    checkOutput("t3_first_dm", 32'(seen), 32'b010);
    applyStimulus(DM, 1'b0, 1'b0, '0, '0);
    arbitrate(who, seen);
    checkOutput("t3_second_if", 32'(seen), 32'b001);
    applyStimulus(IF, 1'b0, 1'b0, '0, '0);
    arbitrate(who, seen);
    checkOutput("t3_third_dma", 32'(seen), 32'b100);
    applyStimulus(DMA, 1'b0, 1'b0, '0, '0);
    arbitrate(who, seen);

    $display("[TB] dma starvation");
    applyStimulus(DM, 1'b1, 1'b0, 12'h030, '0);
    applyStimulus(DMA, 1'b1, 1'b0, 12'h040, '0);
    dm_grants = 0;
    for (int r = 0; r < 20; r++) begin
      arbitrate(who, seen);
      if (seen == 3'b100) break;
      if (seen == 3'b010) dm_grants++;
      applyStimulus(DM, 1'b1, 1'b0, 12'h030 + 12'(r), '0);
    end
    checkOutput("t4_dma_gnt", 32'(seen), 32'b100);
    checkOutput("t4_dm_grants", 32'(dm_grants), 32'd8);
    applyStimulus(DMA, 1'b1, 1'b0, 12'h041, '0);
    arbitrate(who, seen);
    checkOutput("t4_dm_again", 32'(seen), 32'b010);
    for (int k = IF; k <= DMA; k++) applyStimulus(k, 1'b0, 1'b0, '0, '0);
    arbitrate(who, seen);

    $display("[TB] reset during write access");
    saved = init_word(12'h0FF);
    applyStimulus(DMA, 1'b1, 1'b1, 12'h0FF, 16'h1234);
    @(posedge clk); #1;
    checkOutput("t5_gnt", 32'(gnt_vec()), 32'b100);
    checkOutput("t5_we", 32'(bus.mem_write_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_rst_we", 32'(bus.mem_write_enable), 32'd0);
    checkOutput("t5_rst_gnt", 32'(gnt_vec()), 32'd0);
    checkOutput("t5_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_rst_addr", 32'(bus.mem_address), 32'd0);
    checkOutput("t5_rst_data_in", 32'(bus.mem_data_in), 32'd0);
    checkOutput("t5_rst_rdata", 32'(bus.rdata), 32'd0);
    applyStimulus(DMA, 1'b0, 1'b0, '0, '0);
    #2 reset = 1'b0;
    ref_starve = 0;
    ref_rdata  = '0;
    @(posedge clk); #1;
    checkOutput("t5_mem_kept", 32'(mem[12'h0FF]), 32'(saved));
    checkOutput("t5_no_rvalid", 32'(rvalid_vec()), 32'd0);
    checkOutput("t5_idle_busy", 32'(bus.busy), 32'd0);
    applyStimulus(DMA, 1'b1, 1'b0, 12'h0FF, '0);
    arbitrate(who, seen);
    checkOutput("t5_readback", 32'(bus.rdata), 32'(saved));
    applyStimulus(DMA, 1'b0, 1'b0, '0, '0);

    $display("[TB] address extremes");
    applyStimulus(IF, 1'b1, 1'b0, 12'hFFF, '0);
    arbitrate(who, seen);
    checkOutput("t6_top_word", 32'(bus.rdata), 32'(init_word(4095)));
    applyStimulus(IF, 1'b1, 1'b0, 12'h000, '0);
    arbitrate(who, seen);
    checkOutput("t6_bottom_word", 32'(bus.rdata), 32'(init_word(0)));
    applyStimulus(IF, 1'b0, 1'b0, '0, '0);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      arbitrate(who, seen);
      for (int k = IF; k <= DMA; k++) begin
        if (who == k) begin
          if ($urandom_range(0, 1) == 1) new_request(k);
          else applyStimulus(k, 1'b0, 1'b0, '0, '0);
        end else if (!req_of(k) && $urandom_range(0, 9) < 4) begin
          new_request(k);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end
endmodule
